// File: rtl/mandelbrot_pkg.sv
// Shared types and widths for the Mandelbrot pixel scheduler and its result FIFO.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int COORD_W = 12;
    localparam int ADDR_W  = 21;
    localparam int SIZE_W  = 11;

endpackage

// File: rtl/mandelbrot_result_fifo.sv
// Synchronous result FIFO with flush; the head is visible combinationally so the
// consumer sees a new entry the cycle after it is pushed.
module mandelbrot_result_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

    assign head = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Dispatches raster pixels to free point-generator units and gathers their
// out-of-order iteration counts into a result stream.
module mandelbrot_pixel_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int HBI        = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         SYS_RESET,
    input  logic                         frame_start,
    input  logic                         abort,
    input  logic [SIZE_W-1:0]            x_size,
    input  logic [SIZE_W-1:0]            y_size,
    output logic                         busy,
    output logic                         frame_done,
    output logic [NUM_UNITS-1:0]         unit_start,
    output logic [NUM_UNITS*COORD_W-1:0] unit_x,
    output logic [NUM_UNITS*COORD_W-1:0] unit_y,
    input  logic [NUM_UNITS-1:0]         unit_done,
    input  logic [NUM_UNITS*HBI-1:0]     unit_iter,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ADDR_W-1:0]            res_addr,
    output logic [HBI-1:0]               res_iter
);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    state_t               state_reg;
    state_t               state_next;
    logic [SIZE_W-1:0]    x_size_reg;
    logic [SIZE_W-1:0]    y_size_reg;
    logic [SIZE_W-1:0]    x_cnt_reg;
    logic [SIZE_W-1:0]    y_cnt_reg;
    logic [ADDR_W-1:0]    addr_cnt_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     rr_ptr_next;

    logic [NUM_UNITS-1:0] unit_busy;
    logic [NUM_UNITS-1:0] unit_ready;
    logic [NUM_UNITS-1:0] disp_onehot;
    logic [NUM_UNITS-1:0] col_onehot;
    logic [ADDR_W-1:0]    unit_tag [NUM_UNITS];

    logic                 disp_found;
    logic                 col_found;
    logic                 dispatch_en;
    logic                 collect_en;
    logic                 abort_en;
    logic                 last_pixel;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ADDR_W-1:0]    col_tag;
    logic [HBI-1:0]       col_iter;
    logic [ADDR_W+HBI-1:0] fifo_head;

    assign abort_en    = abort && (state_reg != IDLE);
    assign last_pixel  = (x_cnt_reg == x_size_reg - SIZE_W'(1)) &&
                         (y_cnt_reg == y_size_reg - SIZE_W'(1));
    assign pop         = res_valid && res_ready;
    assign dispatch_en = (state_reg == RUN) && !abort_en && disp_found;
    assign collect_en  = ((state_reg == RUN) || (state_reg == DRAIN)) && !abort_en &&
                         col_found && (!fifo_full || pop);

    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == DONE);

    always_comb begin
        disp_found  = 1'b0;
        disp_onehot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!disp_found && !unit_busy[i]) begin
                disp_found     = 1'b1;
                disp_onehot[i] = 1'b1;
            end
        end
    end

    // Two passes give round-robin order: units at or above the pointer first, then the wrap.
    always_comb begin
        col_found   = 1'b0;
        col_onehot  = '0;
        col_tag     = '0;
        col_iter    = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (!col_found && unit_ready[i] &&
                    ((pass == 0) == (IDX_W'(i) >= rr_ptr_reg))) begin
                    col_found     = 1'b1;
                    col_onehot[i] = 1'b1;
                    col_tag       = unit_tag[i];
                    col_iter      = unit_iter[i*HBI +: HBI];
                    rr_ptr_next   = (i == NUM_UNITS - 1) ? '0 : IDX_W'(i + 1);
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    state_next = ((x_size == '0) || (y_size == '0)) ? DONE : RUN;
                end
            end
            RUN:     if (dispatch_en && last_pixel) state_next = DRAIN;
            DRAIN:   if (!(|unit_busy) && fifo_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_en) state_next = IDLE;
    end

    always_ff @(posedge CLK or posedge SYS_RESET) begin
        if (SYS_RESET) begin
            state_reg    <= IDLE;
            x_size_reg   <= '0;
            y_size_reg   <= '0;
            x_cnt_reg    <= '0;
            y_cnt_reg    <= '0;
            addr_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && frame_start) begin
                x_size_reg   <= x_size;
                y_size_reg   <= y_size;
                x_cnt_reg    <= '0;
                y_cnt_reg    <= '0;
                addr_cnt_reg <= '0;
            end else if (dispatch_en) begin
                if (x_cnt_reg == x_size_reg - SIZE_W'(1)) begin
                    x_cnt_reg <= '0;
                    y_cnt_reg <= y_cnt_reg + SIZE_W'(1);
                end else begin
                    x_cnt_reg <= x_cnt_reg + SIZE_W'(1);
                end
                addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
            end
            if (abort_en) begin
                rr_ptr_reg <= '0;
            end else if (collect_en) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : gen_unit
            logic               busy_reg;
            logic [1:0]         blank_reg;
            logic               start_reg;
            logic [COORD_W-1:0] x_reg;
            logic [COORD_W-1:0] y_reg;
            logic [ADDR_W-1:0]  tag_reg;

            // blank_reg masks the done level left over from the unit's previous point.
            always_ff @(posedge CLK or posedge SYS_RESET) begin
                if (SYS_RESET) begin
                    busy_reg  <= 1'b0;
                    blank_reg <= 2'd0;
                    start_reg <= 1'b0;
                    x_reg     <= '0;
                    y_reg     <= '0;
                    tag_reg   <= '0;
                end else begin
                    start_reg <= dispatch_en && disp_onehot[gi];
                    if (abort_en) begin
                        busy_reg  <= 1'b0;
                        blank_reg <= 2'd0;
                    end else if (dispatch_en && disp_onehot[gi]) begin
                        busy_reg  <= 1'b1;
                        blank_reg <= 2'd3;
                        x_reg     <= COORD_W'(x_cnt_reg);
                        y_reg     <= COORD_W'(y_cnt_reg);
                        tag_reg   <= addr_cnt_reg;
                    end else begin
                        if (collect_en && col_onehot[gi]) busy_reg <= 1'b0;
                        if (blank_reg != 2'd0) blank_reg <= blank_reg - 2'd1;
                    end
                end
            end

            assign unit_busy[gi]  = busy_reg;
            assign unit_ready[gi] = busy_reg && unit_done[gi] && (blank_reg == 2'd0);
            assign unit_tag[gi]   = tag_reg;
            assign unit_start[gi] = start_reg;
            assign unit_x[gi*COORD_W +: COORD_W] = x_reg;
            assign unit_y[gi*COORD_W +: COORD_W] = y_reg;
        end
    endgenerate

    mandelbrot_result_fifo #(
        .WIDTH (ADDR_W + HBI),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (CLK),
        .rst       (SYS_RESET),
        .flush     (abort_en),
        .push      (collect_en),
        .push_data ({col_tag, col_iter}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign res_valid = !fifo_empty;
    assign res_addr  = res_valid ? fifo_head[HBI +: ADDR_W] : '0;
    assign res_iter  = res_valid ? fifo_head[HBI-1:0] : '0;

endmodule
